// File: rtl/mul_booth_iter_pkg.sv
// Shared types and sizing helpers for the iterative radix-4 Booth multiplier.
// Used by mul_booth_iter and mul_booth_pp.
package mul_booth_iter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mul_state_e;

  // Decoded Booth digit: magnitude select (one/two) and sign.
  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_sel_t;

  function automatic int ndig(input int xlen);
    return xlen / 2 + 1;
  endfunction

  function automatic int ncyc(input int xlen, input int dpc);
    return (ndig(xlen) + dpc - 1) / dpc;
  endfunction

  // One partial-product row: (XLEN+1)-bit operand, x2, plus sign headroom.
  function automatic int row_w(input int xlen);
    return xlen + 4;
  endfunction

  // 3-bit window {b[2i+1], b[2i], b[2i-1]} -> digit in {-2,-1,0,+1,+2}.
  function automatic booth_sel_t booth_decode(input logic [2:0] win);
    booth_sel_t sel;
    sel.neg = win[2] & ~(win[1] & win[0]);
    sel.one = win[1] ^ win[0];
    sel.two = (win[2] ^ win[1]) & ~(win[1] ^ win[0]);
    return sel;
  endfunction

endpackage

// File: rtl/mul_booth_iter_if.sv
// Request/response handshake bundle for mul_booth_iter; master is the issuing
// side, slave is the multiplier.
interface mul_booth_iter_if #(
  parameter int XLEN = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_in_1_signed;
  logic              req_in_2_signed;
  logic [XLEN-1:0]   req_in_1;
  logic [XLEN-1:0]   req_in_2;
  logic              resp_valid;
  logic              resp_ready;
  logic [2*XLEN-1:0] resp_result;

  modport master (
    output req_valid, req_in_1_signed, req_in_2_signed, req_in_1, req_in_2, resp_ready,
    input  req_ready, resp_valid, resp_result
  );

  modport slave (
    input  req_valid, req_in_1_signed, req_in_2_signed, req_in_1, req_in_2, resp_ready,
    output req_ready, resp_valid, resp_result
  );
endinterface

// File: rtl/mul_booth_pp.sv
// One radix-4 Booth partial-product row: 3-bit window -> sign-extended row in
// one's-complement form plus the +1 carry that completes a negation.
module mul_booth_pp
  import mul_booth_iter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]              win,
  input  logic [XLEN:0]           y,
  output logic [row_w(XLEN)-1:0]  row,
  output logic                    neg
);
  localparam int RW = row_w(XLEN);

  booth_sel_t    sel;
  logic [RW-1:0] y_ext;
  logic [RW-1:0] mag;

  always_comb begin
    sel   = booth_decode(win);
    y_ext = {{3{y[XLEN]}}, y};
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    mag   = '0;
    if (sel.one)      mag = y_ext;
    else if (sel.two) mag = y_ext << 1;
    row = sel.neg ? ~mag : mag;
    neg = sel.neg;
  end

endmodule

// File: rtl/mul_booth_iter.sv
// Iterative radix-4 Booth multiplier, DPC digits per cycle, valid/ready on both
// sides with kill. Optional early termination under `MUL_EARLY_OUT_EN.
module mul_booth_iter
  import mul_booth_iter_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int DPC  = 2
) (
  input logic           clk,
  input logic           reset_n,
  input logic           kill,
  mul_booth_iter_if.slave bus
);
  localparam int NC = ncyc(XLEN, DPC);
  localparam int RW = row_w(XLEN);
  localparam int SH = 2 * DPC;
  localparam int PW = RW + SH;
  // New rows enter at the top of acc so nothing shifted right is ever lost;
  // after NC steps the product sits at bit 0.
  localparam int S  = SH * (NC - 1);
  localparam int AW = S + PW;
  localparam int CW = $clog2(NC + 1);

  mul_state_e      state_q, state_d;
  logic [XLEN+1:0] x_q;   // {ext, in_1, implicit 0 below bit 0}
  logic [XLEN:0]   y_q;
  logic [CW-1:0]   cnt_q;
  logic [AW-1:0]   acc_q;

  logic [RW-1:0]   row [DPC];
  logic [DPC-1:0]  neg;
  logic [PW-1:0]   pp_sum;
  logic [AW-1:0]   acc_shr, acc_step, acc_fin;
  logic            early;
  logic            accept;

  for (genvar j = 0; j < DPC; j++) begin : g_pp
    mul_booth_pp #(.XLEN(XLEN)) u_pp (
      .win (x_q[2*j+2:2*j]),
      .y   (y_q),
      .row (row[j]),
      .neg (neg[j])
    );
  end

  always_comb begin
    pp_sum = '0;
    for (int j = 0; j < DPC; j++) begin
      pp_sum = pp_sum + ({{SH{row[j][RW-1]}}, row[j]} << (2 * j))
                      + (PW'(neg[j]) << (2 * j));
    end
  end

`ifdef MUL_EARLY_OUT_EN
  logic [CW-1:0] cnt_rem;
`endif

  always_comb begin
    acc_shr  = $signed(acc_q) >>> SH;
    acc_step = acc_shr + {pp_sum, {S{1'b0}}};
`ifdef MUL_EARLY_OUT_EN
    cnt_rem = cnt_q - CW'(1);
    // Remaining multiplier bits all equal -> every later digit is zero.
    early   = (&x_q[XLEN+1:SH]) | ~(|x_q[XLEN+1:SH]);
    acc_fin = early ? $unsigned($signed(acc_step) >>> (SH * int'(cnt_rem))) : acc_step;
`else
    early   = 1'b0;
    acc_fin = acc_step;
`endif
  end

  assign accept          = (state_q == IDLE) && bus.req_valid && !kill;
  assign bus.req_ready   = (state_q == IDLE) && !kill;
  assign bus.resp_valid  = (state_q == DONE);
  assign bus.resp_result = acc_q[2*XLEN-1:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY: begin
        if (kill)                            state_d = IDLE;
        else if (cnt_q == CW'(1) || early)   state_d = DONE;
      end
      DONE:    if (kill || bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: datapath registers are reset too, so resp_result reads 0 out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q   <= '0;
      y_q   <= '0;
      cnt_q <= '0;
      acc_q <= '0;
    end else if (accept) begin
      x_q   <= {bus.req_in_1_signed & bus.req_in_1[XLEN-1], bus.req_in_1, 1'b0};
      y_q   <= {bus.req_in_2_signed & bus.req_in_2[XLEN-1], bus.req_in_2};
      cnt_q <= CW'(NC);
      acc_q <= '0;
    end else if (state_q == BUSY && !kill) begin
      x_q   <= $signed(x_q) >>> SH;
      cnt_q <= cnt_q - CW'(1);
      acc_q <= acc_fin;
    end
  end

endmodule
